// File: rtl/hdp_seq_pkg.sv
// hdp_seq_pkg: shared encodings, HDP register map and script entry format for the HDP sequencer.
package hdp_seq_pkg;
  typedef enum logic [1:0] {OP_WRITE = 2'd0, OP_RDCHK = 2'd1, OP_DELAY = 2'd2, OP_END = 2'd3} op_e;
  typedef enum logic [1:0] {MODE_SETUP = 2'd0, MODE_ACTIVATE = 2'd1, MODE_SHUTDOWN = 2'd2, MODE_ILLEGAL = 2'd3} mode_e;
  typedef enum logic [2:0] {ERR_NONE = 3'd0, ERR_MODE = 3'd1, ERR_ID = 3'd2, ERR_TIMEOUT = 3'd3} err_e;
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT_SPI, S_CHECK, S_DELAY, S_RETRY_WAIT, S_DONE, S_ERROR
  } state_e;
  typedef struct packed {
    op_e        op;
    logic [6:0] addr;
    logic [7:0] data;
  } entry_t;
  localparam logic [6:0] REG_MODE    = 7'h01;
  localparam logic [6:0] REG_CFG_A   = 7'h06;
  localparam logic [6:0] REG_CFG_B   = 7'h07;
  localparam logic [6:0] REG_SERIAL  = 7'h08;
  localparam logic [6:0] REG_CLOCK   = 7'h09;
  localparam logic [6:0] REG_ID      = 7'h78;
  localparam logic [7:0] ID_EXPECTED = 8'h20;
  localparam logic [7:0] SER_CMD_A   = 8'h30;
  localparam logic [7:0] SER_CMD_B   = 8'h40;
  localparam logic [7:0] HDP_OFF     = 8'h00;
  localparam logic [7:0] HDP_STANDBY = 8'h01;
  localparam logic [7:0] HDP_ACTIVE  = 8'h02;
  // DELAY entries carry a selector in the data byte rather than a count.
  localparam logic [7:0] DLY_STANDBY  = 8'h00;
  localparam logic [7:0] DLY_SHUTDOWN = 8'h01;
  function automatic entry_t mk_entry(op_e op, logic [6:0] addr, logic [7:0] data);
    return '{op: op, addr: addr, data: data};
  endfunction
endpackage

// File: rtl/hdp_sequencer_if.sv
// hdp_sequencer_if: begin/done handshake between the HDP sequencer (master) and the SPI master (slave).
interface hdp_sequencer_if;
  logic       o_spiTxBegin;
  logic [6:0] o_spiTxAddress;
  logic [7:0] o_spiTxData;
  logic       i_spiTxDone;
  logic       o_spiRxBegin;
  logic [6:0] o_spiRxAddress;
  logic [7:0] i_spiRxData;
  logic       i_spiRxDone;
  modport master (
    output o_spiTxBegin, o_spiTxAddress, o_spiTxData, o_spiRxBegin, o_spiRxAddress,
    input  i_spiTxDone, i_spiRxData, i_spiRxDone
  );
  modport slave (
    input  o_spiTxBegin, o_spiTxAddress, o_spiTxData, o_spiRxBegin, o_spiRxAddress,
    output i_spiTxDone, i_spiRxData, i_spiRxDone
  );
endinterface

// File: rtl/hdp_seq_rom.sv
// hdp_seq_rom: combinational (mode, step) -> script entry lookup; anything out of range reads as END.
module hdp_seq_rom
  import hdp_seq_pkg::*;
#(
  parameter int CLOCK_MHZ = 50
) (
  input  mode_e      mode_i,
  input  logic [3:0] step_i,
  output entry_t     entry_o
);
  always_comb begin
    entry_o = mk_entry(OP_END, 7'h00, 8'h00);
    case (mode_i)
      MODE_SETUP:
        case (step_i)
          4'd0:    entry_o = mk_entry(OP_RDCHK, REG_ID, ID_EXPECTED);
          4'd1:    entry_o = mk_entry(OP_WRITE, REG_CFG_A, 8'h00);
          4'd2:    entry_o = mk_entry(OP_WRITE, REG_CFG_B, 8'h00);
          4'd3:    entry_o = mk_entry(OP_WRITE, REG_SERIAL, SER_CMD_A);
          4'd4:    entry_o = mk_entry(OP_WRITE, REG_SERIAL, SER_CMD_B);
          4'd5:    entry_o = mk_entry(OP_WRITE, REG_CLOCK, 8'(CLOCK_MHZ));
          4'd6:    entry_o = mk_entry(OP_WRITE, REG_MODE, HDP_STANDBY);
          4'd7:    entry_o = mk_entry(OP_DELAY, 7'h00, DLY_STANDBY);
          default: entry_o = mk_entry(OP_END, 7'h00, 8'h00);
        endcase
      MODE_ACTIVATE:
        entry_o = step_i == 4'd0 ? mk_entry(OP_WRITE, REG_MODE, HDP_ACTIVE) : mk_entry(OP_END, 7'h00, 8'h00);
      MODE_SHUTDOWN:
        entry_o = step_i == 4'd0 ? mk_entry(OP_WRITE, REG_MODE, HDP_OFF) :
                  step_i == 4'd1 ? mk_entry(OP_DELAY, 7'h00, DLY_SHUTDOWN) : mk_entry(OP_END, 7'h00, 8'h00);
      default: entry_o = mk_entry(OP_END, 7'h00, 8'h00);
    endcase
  end
endmodule

// File: rtl/hdp_sequencer.sv
// hdp_sequencer: runs the SETUP/ACTIVATE/SHUTDOWN HDP register scripts over the SPI begin/done handshake,
// with read-verify retries, script delays and an SPI watchdog. HDP_SEQ_TRACE_EN adds a transaction trace port.
module hdp_sequencer
  import hdp_seq_pkg::*;
#(
  parameter int CLOCK_MHZ      = 50,
  parameter int STANDBY_DELAY  = 960001,
  parameter int SHUTDOWN_DELAY = 75001,
  parameter int MAX_RETRIES    = 3,
  parameter int RETRY_DELAY    = 50000000,
  parameter int SPI_TIMEOUT    = 65535,
  parameter int DELAY_W        = 32
) (
  input  logic       i_clock,
  input  logic       i_resetN,
  input  logic       i_start,
  input  logic [1:0] i_mode,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [2:0] o_errCode,
  output logic [3:0] o_step,
  hdp_sequencer_if.master spi
`ifdef HDP_SEQ_TRACE_EN
  ,
  output logic        o_traceValid,
  output logic [15:0] o_traceData
`endif
);
  localparam logic [DELAY_W-1:0] LD_STANDBY  = DELAY_W'(STANDBY_DELAY - 1);
  localparam logic [DELAY_W-1:0] LD_SHUTDOWN = DELAY_W'(SHUTDOWN_DELAY - 1);
  localparam logic [DELAY_W-1:0] LD_RETRY    = DELAY_W'(RETRY_DELAY - 1);
  localparam logic [DELAY_W-1:0] LD_TIMEOUT  = DELAY_W'(SPI_TIMEOUT - 1);
  localparam logic [DELAY_W-1:0] CNT_ONE     = DELAY_W'(1);
  state_e             state_q;
  mode_e              mode_q;
  err_e               err_q;
  entry_t             entry_q;
  entry_t             rom_entry;
  logic [3:0]         step_q;
  logic [3:0]         rom_step;
  logic [7:0]         retry_q;
  logic [7:0]         rx_q;
  logic [DELAY_W-1:0] cnt_q;
  logic               busy_q, done_q, error_q;
  logic               tx_begin_q, rx_begin_q;
  logic [6:0]         tx_addr_q, rx_addr_q;
  logic [7:0]         tx_data_q;
  logic               is_rd, spi_done, at_end;
`ifdef HDP_SEQ_TRACE_EN
  logic               trace_valid_q;
  logic [15:0]        trace_data_q;
`endif
  // Peek at the next step while finishing one so a trailing END goes straight to DONE.
  assign rom_step = (state_q == S_WAIT_SPI || state_q == S_CHECK || state_q == S_DELAY) ? step_q + 4'd1 : step_q;
  hdp_seq_rom #(.CLOCK_MHZ(CLOCK_MHZ)) u_rom (
    .mode_i (mode_q),
    .step_i (rom_step),
    .entry_o(rom_entry)
  );
  assign is_rd    = entry_q.op == OP_RDCHK;
  assign spi_done = is_rd ? spi.i_spiRxDone : spi.i_spiTxDone;
  assign at_end   = rom_entry.op == OP_END;
  always_ff @(posedge i_clock or negedge i_resetN) begin
    if (!i_resetN) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_SETUP;
      err_q      <= ERR_NONE;
      entry_q    <= '0;
      step_q     <= '0;
      retry_q    <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      tx_begin_q <= 1'b0;
      rx_begin_q <= 1'b0;
      tx_addr_q  <= '0;
      tx_data_q  <= '0;
      rx_addr_q  <= '0;
`ifdef HDP_SEQ_TRACE_EN
      trace_valid_q <= 1'b0;
      trace_data_q  <= '0;
`endif
    end else begin
      tx_begin_q <= 1'b0;
      rx_begin_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef HDP_SEQ_TRACE_EN
      trace_valid_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          state_q <= S_IDLE;
          if (i_start) begin
            mode_q  <= mode_e'(i_mode);
            step_q  <= '0;
            retry_q <= '0;
            state_q <= i_mode == MODE_ILLEGAL ? S_ERROR : S_FETCH;
            busy_q  <= i_mode != MODE_ILLEGAL;
            error_q <= i_mode == MODE_ILLEGAL;
            err_q   <= i_mode == MODE_ILLEGAL ? ERR_MODE : ERR_NONE;
          end
        end
        S_FETCH: begin
          entry_q <= rom_entry;
          state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt_q <= entry_q.op == OP_DELAY ? (entry_q.data[0] ? LD_SHUTDOWN : LD_STANDBY) : LD_TIMEOUT;
          if (entry_q.op == OP_WRITE) begin
            tx_begin_q <= 1'b1;
            tx_addr_q  <= entry_q.addr;
            tx_data_q  <= entry_q.data;
          end
          if (is_rd) begin
            rx_begin_q <= 1'b1;
            rx_addr_q  <= entry_q.addr;
          end
          state_q <= entry_q.op == OP_DELAY ? S_DELAY : entry_q.op == OP_END ? S_DONE : S_WAIT_SPI;
          if (entry_q.op == OP_END) begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
          end
        end
        S_WAIT_SPI: begin
          // Done is tested first so a completion on the final watchdog cycle still counts.
          if (spi_done) begin
`ifdef HDP_SEQ_TRACE_EN
            trace_valid_q <= 1'b1;
            trace_data_q  <= {2'b00, step_q, entry_q.op, is_rd ? spi.i_spiRxData : entry_q.data};
`endif
            if (is_rd) begin
              rx_q    <= spi.i_spiRxData;
              state_q <= S_CHECK;
            end else begin
              step_q  <= step_q + 4'd1;
              state_q <= at_end ? S_DONE : S_FETCH;
              done_q  <= at_end;
              busy_q  <= !at_end;
            end
          end else if (cnt_q == '0) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= ERR_TIMEOUT;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_CHECK: begin
          if (rx_q == entry_q.data) begin
            step_q  <= step_q + 4'd1;
            state_q <= at_end ? S_DONE : S_FETCH;
            done_q  <= at_end;
            busy_q  <= !at_end;
          end else if (retry_q < 8'(MAX_RETRIES)) begin
            retry_q <= retry_q + 8'd1;
            cnt_q   <= LD_RETRY;
            state_q <= S_RETRY_WAIT;
          end else begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= ERR_ID;
          end
        end
        S_RETRY_WAIT: begin
          state_q <= cnt_q == '0 ? S_FETCH : S_RETRY_WAIT;
          cnt_q   <= cnt_q - CNT_ONE;
        end
        S_DELAY: begin
          if (cnt_q <= CNT_ONE) begin
            step_q  <= step_q + 4'd1;
            state_q <= at_end ? S_DONE : S_FETCH;
            done_q  <= at_end;
            busy_q  <= !at_end;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  assign o_busy             = busy_q;
  assign o_done             = done_q;
  assign o_error            = error_q;
  assign o_errCode          = err_q;
  assign o_step             = step_q;
  assign spi.o_spiTxBegin   = tx_begin_q;
  assign spi.o_spiTxAddress = tx_addr_q;
  assign spi.o_spiTxData    = tx_data_q;
  assign spi.o_spiRxBegin   = rx_begin_q;
  assign spi.o_spiRxAddress = rx_addr_q;
`ifdef HDP_SEQ_TRACE_EN
  assign o_traceValid = trace_valid_q;
  assign o_traceData  = trace_data_q;
`endif
endmodule

// File: tb/tb_hdp_sequencer.sv
// tb_hdp_sequencer: directed bench for hdp_sequencer with a small SPI responder answering each begin after 2 cycles.
module tb_hdp_sequencer;
  localparam int STBY    = 40;
  localparam int SHUT    = 25;
  localparam int RETRIES = 2;
  localparam int RDLY    = 30;
  localparam int TMO     = 20;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       busy, done, error;
  logic [2:0] err_code;
  logic [3:0] step;
`ifdef HDP_SEQ_TRACE_EN
  logic        trace_valid;
  logic [15:0] trace_data;
`endif
  hdp_sequencer_if spi ();
  hdp_sequencer #(
    .CLOCK_MHZ(50), .STANDBY_DELAY(STBY), .SHUTDOWN_DELAY(SHUT), .MAX_RETRIES(RETRIES),
    .RETRY_DELAY(RDLY), .SPI_TIMEOUT(TMO), .DELAY_W(32)
  ) dut (
    .i_clock(clk), .i_resetN(rst_n), .i_start(start), .i_mode(mode),
    .o_busy(busy), .o_done(done), .o_error(error), .o_errCode(err_code), .o_step(step),
    .spi(spi)
`ifdef HDP_SEQ_TRACE_EN
    , .o_traceValid(trace_valid), .o_traceData(trace_data)
`endif
  );
  always #5 clk = ~clk;
  int cyc;
  always @(posedge clk) cyc <= cyc + 1;
  int n_cmp, n_bad;
  int n_wr, n_rd, overlap, tx_cnt, rx_cnt, rx_idx, rx_n, tx_done_cyc;
  logic tx_hold = 1'b0;
  logic [6:0] wr_addr[16];
  logic [7:0] wr_data[16];
  int         wr_cyc[16];
  logic [6:0] rd_addr[16];
  int         rd_cyc[16];
  int         rx_done_cyc[16];
  logic [7:0] rx_vals[4];
  int   start_cyc, end_cyc;
  logic got_done, got_err, ended;
  // SPI responder: all activity on the falling edge, away from the DUT's sampling edge.
  always @(negedge clk) begin
    spi.i_spiTxDone = 1'b0;
    spi.i_spiRxDone = 1'b0;
    spi.i_spiRxData = 8'h00;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0 && !tx_hold) begin
        spi.i_spiTxDone = 1'b1;
        tx_done_cyc = cyc;
      end
    end
    if (rx_cnt > 0) begin
      rx_cnt--;
      if (rx_cnt == 0) begin
        spi.i_spiRxDone = 1'b1;
        spi.i_spiRxData = rx_vals[(rx_idx < rx_n) ? rx_idx : rx_n - 1];
        if (rx_idx < 16) rx_done_cyc[rx_idx] = cyc;
        rx_idx++;
      end
    end
    if (spi.o_spiTxBegin === 1'b1) begin
      if (tx_cnt > 0 || rx_cnt > 0) overlap++;
      if (n_wr < 16) begin
        wr_addr[n_wr] = spi.o_spiTxAddress;
        wr_data[n_wr] = spi.o_spiTxData;
        wr_cyc[n_wr]  = cyc;
      end
      n_wr++;
      tx_cnt = 2;
    end
    if (spi.o_spiRxBegin === 1'b1) begin
      if (tx_cnt > 0 || rx_cnt > 0) overlap++;
      if (n_rd < 16) begin
        rd_addr[n_rd] = spi.o_spiRxAddress;
        rd_cyc[n_rd]  = cyc;
      end
      n_rd++;
      rx_cnt = 2;
    end
  end
  task automatic clear_log();
    n_wr = 0; n_rd = 0; overlap = 0; rx_idx = 0; tx_done_cyc = 0;
  endtask
  task automatic kick(input logic [1:0] m);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_end(input int limit);
    ended = 1'b0; got_done = 1'b0; got_err = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done || error) begin
        ended = 1'b1; got_done = done; got_err = error; end_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, step, spi.o_spiTxBegin, spi.o_spiRxBegin} !== 9'd0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got busy=%b done=%b error=%b step=%0d txb=%b rxb=%b want all 0",
               busy, done, error, step, spi.o_spiTxBegin, spi.o_spiRxBegin);
    end
    n_cmp++;
    if ({err_code, spi.o_spiTxAddress, spi.o_spiTxData, spi.o_spiRxAddress} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_data: got err=%0d txa=%h txd=%h rxa=%h want 0", err_code,
               spi.o_spiTxAddress, spi.o_spiTxData, spi.o_spiRxAddress);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_setup();
    logic [14:0] exp_wr[6];
    exp_wr = '{{7'h06, 8'h00}, {7'h07, 8'h00}, {7'h08, 8'h30}, {7'h08, 8'h40}, {7'h09, 8'd50}, {7'h01, 8'h01}};
    clear_log(); rx_vals[0] = 8'h20; rx_n = 1;
    kick(2'd0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL setup_busy: got %b want 1", busy); end
    wait_end(300);
    n_cmp++;
    if (!(ended && got_done && !got_err)) begin
      n_bad++; $display("FAIL setup_done: got ended=%b done=%b err=%b want done", ended, got_done, got_err);
    end
    n_cmp++;
    if ({busy, err_code} !== 4'd0) begin n_bad++; $display("FAIL setup_state: got busy=%b err=%0d want 0/0", busy, err_code); end
    n_cmp++;
    if (n_rd !== 1 || rd_addr[0] !== 7'h78) begin
      n_bad++; $display("FAIL setup_read: got n=%0d addr=%h want 1 read of 78", n_rd, rd_addr[0]);
    end
    n_cmp++;
    if (rd_cyc[0] - start_cyc !== 3) begin n_bad++; $display("FAIL start_latency: got %0d want 3", rd_cyc[0] - start_cyc); end
    n_cmp++;
    if (n_wr !== 6) begin n_bad++; $display("FAIL setup_nwr: got %0d want 6", n_wr); end
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({wr_addr[i], wr_data[i]} !== exp_wr[i]) begin
        n_bad++; $display("FAIL setup_wr%0d: got %h<-%h want %h<-%h", i, wr_addr[i], wr_data[i], exp_wr[i][14:8], exp_wr[i][7:0]);
      end
    end
    n_cmp++;
    if (end_cyc - tx_done_cyc < STBY) begin
      n_bad++; $display("FAIL standby_delay: got %0d cycles want >= %0d", end_cyc - tx_done_cyc, STBY);
    end
    n_cmp++;
    if (overlap !== 0) begin n_bad++; $display("FAIL setup_overlap: got %0d want 0", overlap); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_retry();
    clear_log(); rx_vals[0] = 8'h11; rx_vals[1] = 8'h20; rx_n = 2;
    kick(2'd0);
    wait_end(400);
    n_cmp++;
    if (!(ended && got_done) || err_code !== 3'd0) begin
      n_bad++; $display("FAIL retry_done: got done=%b err=%0d want done err 0", got_done, err_code);
    end
    n_cmp++;
    if (n_rd !== 2) begin n_bad++; $display("FAIL retry_nrd: got %0d want 2", n_rd); end
    n_cmp++;
    if (rd_cyc[1] - rx_done_cyc[0] !== RDLY + 4) begin
      n_bad++; $display("FAIL retry_gap: got %0d want %0d", rd_cyc[1] - rx_done_cyc[0], RDLY + 4);
    end
    n_cmp++;
    if (n_wr !== 6) begin n_bad++; $display("FAIL retry_nwr: got %0d want 6", n_wr); end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_id_fail();
    clear_log(); rx_vals[0] = 8'h00; rx_n = 1;
    kick(2'd0);
    wait_end(400);
    n_cmp++;
    if (!(ended && got_err && !got_done)) begin
      n_bad++; $display("FAIL id_error: got ended=%b err=%b done=%b want error", ended, got_err, got_done);
    end
    n_cmp++;
    if (err_code !== 3'd2 || busy !== 1'b0) begin n_bad++; $display("FAIL id_code: got %0d busy=%b want 2/0", err_code, busy); end
    n_cmp++;
    if (n_rd !== RETRIES + 1 || n_wr !== 0) begin
      n_bad++; $display("FAIL id_traffic: got rd=%0d wr=%0d want rd=%0d wr=0", n_rd, n_wr, RETRIES + 1);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_timeout();
    clear_log(); tx_hold = 1'b1;
    kick(2'd2);
    wait_end(100);
    tx_hold = 1'b0;
    n_cmp++;
    if (!(ended && got_err) || err_code !== 3'd3) begin
      n_bad++; $display("FAIL timeout_code: got err=%b code=%0d want 1/3", got_err, err_code);
    end
    n_cmp++;
    if (end_cyc - wr_cyc[0] !== TMO) begin n_bad++; $display("FAIL timeout_cycles: got %0d want %0d", end_cyc - wr_cyc[0], TMO); end
    n_cmp++;
    if (n_wr !== 1 || {wr_addr[0], wr_data[0]} !== {7'h01, 8'h00}) begin
      n_bad++; $display("FAIL timeout_wr: got n=%0d %h<-%h want 1 of 01<-00", n_wr, wr_addr[0], wr_data[0]);
    end
    repeat (2) @(negedge clk);
    clear_log();
    kick(2'd3);
    wait_end(10);
    n_cmp++;
    if (!(ended && got_err) || err_code !== 3'd1) begin
      n_bad++; $display("FAIL badmode_code: got err=%b code=%0d want 1/1", got_err, err_code);
    end
    n_cmp++;
    if (end_cyc - start_cyc !== 1 || n_wr + n_rd !== 0) begin
      n_bad++; $display("FAIL badmode_fast: got lat=%0d spi=%0d want 1/0", end_cyc - start_cyc, n_wr + n_rd);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_shutdown();
    clear_log();
    kick(2'd2);
    wait_end(200);
    n_cmp++;
    if (!(ended && got_done) || err_code !== 3'd0) begin
      n_bad++; $display("FAIL shutdown_done: got done=%b code=%0d want 1/0", got_done, err_code);
    end
    n_cmp++;
    if (end_cyc - tx_done_cyc < SHUT || n_wr !== 1) begin
      n_bad++; $display("FAIL shutdown_delay: got %0d cycles n_wr=%0d want >=%0d and 1", end_cyc - tx_done_cyc, n_wr, SHUT);
    end
    repeat (2) @(negedge clk);
  endtask
  task automatic test_back_to_back();
    logic stray;
    clear_log();
    kick(2'd1);
    start = 1'b1; mode = 2'd3;
    @(negedge clk);
    start = 1'b0;
    wait_end(50);
    n_cmp++;
    if (!(ended && got_done && !got_err)) begin
      n_bad++; $display("FAIL activate_done: got done=%b err=%b want 1/0", got_done, got_err);
    end
    n_cmp++;
    if (end_cyc - tx_done_cyc !== 1) begin n_bad++; $display("FAIL activate_lat: got %0d want 1", end_cyc - tx_done_cyc); end
    n_cmp++;
    if (n_wr !== 1 || {wr_addr[0], wr_data[0]} !== {7'h01, 8'h02}) begin
      n_bad++; $display("FAIL activate_wr: got n=%0d %h<-%h want 1 of 01<-02", n_wr, wr_addr[0], wr_data[0]);
    end
    stray = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || error || busy) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0 || n_wr !== 1 || n_rd !== 0 || err_code !== 3'd0) begin
      n_bad++; $display("FAIL busy_start_ignored: got stray=%b wr=%0d rd=%0d code=%0d want 0/1/0/0", stray, n_wr, n_rd, err_code);
    end
  endtask
  task automatic test_reset_mid();
    logic stray;
    clear_log(); rx_vals[0] = 8'h20; rx_n = 1;
    kick(2'd0);
    for (int i = 0; i < 200 && n_wr < 6; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || step !== 4'd7) begin n_bad++; $display("FAIL mid_delay: got busy=%b step=%0d want 1/7", busy, step); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, error, err_code, step, spi.o_spiTxBegin, spi.o_spiRxBegin,
         spi.o_spiTxAddress, spi.o_spiTxData, spi.o_spiRxAddress} !== 34'd0) begin
      n_bad++; $display("FAIL async_reset: got busy=%b step=%0d txa=%h txd=%h rxa=%h want all 0",
                        busy, step, spi.o_spiTxAddress, spi.o_spiTxData, spi.o_spiRxAddress);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (done || error || busy) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0 || n_wr !== 6 || n_rd !== 1) begin
      n_bad++; $display("FAIL post_reset_quiet: got stray=%b wr=%0d rd=%0d want 0/6/1", stray, n_wr, n_rd);
    end
  endtask
  initial begin
    test_reset();
    test_setup();
    test_retry();
    test_id_fail();
    test_timeout();
    test_shutdown();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want bench to finish");
    $fatal(1, "bench watchdog expired");
  end
endmodule
